// File: rtl/board_logic_if.sv
// Board command/status bundle: move and load requests in, board image and status out.
interface board_logic_if;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        load_en;
  logic [63:0] load_values;
  logic [63:0] values;
  logic        busy;
  logic        move_done;
  logic        game_over;
  logic        win;

  modport master (
    output move_valid, move_dir, load_en, load_values,
    input  values, busy, move_done, game_over, win
  );

  modport slave (
    input  move_valid, move_dir, load_en, load_values,
    output values, busy, move_done, game_over, win
  );
endinterface

// File: rtl/board_logic.sv
// 2048 board engine: one line slid/merged per cycle, LFSR-driven tile spawn,
// registered game_over/win evaluation.
module board_logic (
  input  logic          i_clk,
  input  logic          i_rst_n,
  board_logic_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LINE0, S_LINE1, S_LINE2, S_LINE3, S_SPAWN, S_CHECK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_values;
  logic [15:0] r_lfsr;
  logic [1:0]  r_dir;
  logic        r_changed, r_is_move, r_init_pend, r_spawn_more;
  logic [3:0]  r_probe, r_probe_cnt;
  logic        r_busy, r_move_done, r_game_over, r_win;

  logic [1:0]  w_line_n;
  logic [5:0]  w_idx [0:3];
  logic [15:0] w_line_in, w_line_out;
  logic [63:0] w_values_line;
  logic        w_line_changed, w_probe_empty, w_lfsr_fb;
  logic [3:0]  w_spawn_val;

  // Position p (leading edge first) of line n, mapped to a board cell.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] n,
                                          input logic [1:0] p);
    case (dir)
      2'b00:   return {p, n};
      2'b01:   return {~p, n};
      2'b10:   return {n, p};
      2'b11:   return {n, ~p};
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] slide_line(input logic [15:0] line);
    logic [3:0] c [0:4];
    logic [3:0] o [0:3];
    logic [2:0] j;
    logic       skip;
    for (int k = 0; k < 5; k++) c[k] = 4'd0;
    for (int k = 0; k < 4; k++) o[k] = 4'd0;
    j = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (line[4*i +: 4] != 4'd0) begin
        c[j[1:0]] = line[4*i +: 4];
        j = j + 3'd1;
      end
    end
    // c[4] stays zero so the last compacted tile never finds a partner.
    j = 3'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 4'd0) begin
        if (c[i] == c[i+1]) begin
          o[j[1:0]] = (c[i] == 4'hF) ? 4'hF : c[i] + 4'd1;
          skip = 1'b1;
        end else begin
          o[j[1:0]] = c[i];
        end
        j = j + 3'd1;
      end
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  function automatic logic calc_game_over(input logic [63:0] b);
    logic over;
    over = 1'b1;
    for (int i = 0; i < 16; i++)
      if (b[4*i +: 4] == 4'd0) over = 1'b0;
    for (int i = 0; i < 15; i++)
      if (i[1:0] != 2'd3 && b[4*i +: 4] == b[4*(i+1) +: 4]) over = 1'b0;
    for (int i = 0; i < 12; i++)
      if (b[4*i +: 4] == b[4*(i+4) +: 4]) over = 1'b0;
    return over;
  endfunction

  function automatic logic calc_win(input logic [63:0] b);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 16; i++)
      if (b[4*i +: 4] >= 4'd11) w = 1'b1;
    return w;
  endfunction

  // Line datapath: gather the active line, slide it, scatter it back.
  always_comb begin
    case (r_state)
      S_LINE1: w_line_n = 2'd1;
      S_LINE2: w_line_n = 2'd2;
      S_LINE3: w_line_n = 2'd3;
      default: w_line_n = 2'd0;
    endcase
    w_line_in = 16'd0;
    for (int p = 0; p < 4; p++) begin
      w_idx[p] = {cell_idx(r_dir, w_line_n, 2'(p)), 2'b00};
      w_line_in[4*p +: 4] = r_values[w_idx[p] +: 4];
    end
    w_line_out     = slide_line(w_line_in);
    w_line_changed = (w_line_out != w_line_in);
    w_values_line  = r_values;
    for (int p = 0; p < 4; p++)
      w_values_line[w_idx[p] +: 4] = w_line_out[4*p +: 4];
    w_probe_empty = (r_values[{r_probe, 2'b00} +: 4] == 4'd0);
    w_spawn_val   = (r_lfsr[15:13] == 3'b111) ? 4'd2 : 4'd1;
    w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_init_pend)               w_state_nxt = S_INIT;
        else if (io_bus.load_en)       w_state_nxt = S_CHECK;
        else if (io_bus.move_valid)    w_state_nxt = S_LINE0;
        else                           w_state_nxt = S_IDLE;
      end
      S_INIT:  w_state_nxt = S_SPAWN;
      S_LINE0: w_state_nxt = S_LINE1;
      S_LINE1: w_state_nxt = S_LINE2;
      S_LINE2: w_state_nxt = S_LINE3;
      S_LINE3: begin
        if (r_changed || w_line_changed) w_state_nxt = S_SPAWN;
        else                             w_state_nxt = S_CHECK;
      end
      S_SPAWN: begin
        if ((w_probe_empty || r_probe_cnt == 4'd15) && !r_spawn_more) w_state_nxt = S_CHECK;
        else                                                          w_state_nxt = S_SPAWN;
      end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Board, LFSR, spawn bookkeeping and registered status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_values     <= 64'd0;
      r_lfsr       <= 16'hACE1;
      r_dir        <= 2'd0;
      r_changed    <= 1'b0;
      r_is_move    <= 1'b0;
      r_init_pend  <= 1'b1;
      r_spawn_more <= 1'b0;
      r_probe      <= 4'd0;
      r_probe_cnt  <= 4'd0;
      r_busy       <= 1'b0;
      r_move_done  <= 1'b0;
      r_game_over  <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
      r_busy      <= (w_state_nxt != S_IDLE);
      r_move_done <= (r_state == S_CHECK) && r_is_move;
      case (r_state)
        S_IDLE: begin
          if (r_init_pend) begin
            r_init_pend <= 1'b0;
          end else if (io_bus.load_en) begin
            r_values  <= io_bus.load_values;
            r_is_move <= 1'b0;
          end else if (io_bus.move_valid) begin
            r_dir     <= io_bus.move_dir;
            r_changed <= 1'b0;
            r_is_move <= 1'b1;
          end
        end
        S_INIT: begin
          r_probe      <= r_lfsr[3:0];
          r_probe_cnt  <= 4'd0;
          r_spawn_more <= 1'b1;
          r_is_move    <= 1'b0;
        end
        S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
          r_values     <= w_values_line;
          r_changed    <= r_changed | w_line_changed;
          r_probe      <= r_lfsr[3:0];
          r_probe_cnt  <= 4'd0;
          r_spawn_more <= 1'b0;
        end
        S_SPAWN: begin
          if (w_probe_empty) r_values[{r_probe, 2'b00} +: 4] <= w_spawn_val;
          // A finished sequence re-arms the probe for the second INIT spawn.
          if (w_probe_empty || r_probe_cnt == 4'd15) begin
            r_probe      <= r_lfsr[3:0];
            r_probe_cnt  <= 4'd0;
            r_spawn_more <= 1'b0;
          end else begin
            r_probe     <= r_probe + 4'd1;
            r_probe_cnt <= r_probe_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          r_game_over <= calc_game_over(r_values);
          r_win       <= calc_win(r_values);
        end
        default: ;
      endcase
    end
  end

  assign io_bus.values    = r_values;
  assign io_bus.busy      = r_busy;
  assign io_bus.move_done = r_move_done;
  assign io_bus.game_over = r_game_over;
  assign io_bus.win       = r_win;

endmodule
